// File: rtl/dp_operand_feeder.sv
// dp_operand_feeder: packs element beats into operand vectors, starts the dot-product engine and returns its result or a timeout error
module dp_operand_feeder #(
    parameter int N_ELEM  = 8,
    parameter int ELEM_W  = 8,
    parameter int RES_W   = 19,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ELEM_W-1:0]        in_a,
    input  logic [ELEM_W-1:0]        in_b,
    output logic [N_ELEM*ELEM_W-1:0] vec_a,
    output logic [N_ELEM*ELEM_W-1:0] vec_b,
    output logic                     compute,
    input  logic                     dp_valid,
    input  logic [RES_W-1:0]         dp_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [RES_W-1:0]         res_data,
    output logic                     res_err,
    output logic                     busy
);
    localparam int IW = $clog2(N_ELEM);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, RESP} state_t;
    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    // Single FSM; every output is a register updated together with the state transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            vec_a     <= '0;
            vec_b     <= '0;
            compute   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        vec_a[idx*ELEM_W +: ELEM_W] <= in_a;
                        vec_b[idx*ELEM_W +: ELEM_W] <= in_b;
                        if (idx == IW'(N_ELEM - 1)) begin
                            idx      <= '0;
                            state    <= ISSUE;
                            in_ready <= 1'b0;
                            compute  <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    compute <= 1'b0;
                    cnt     <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (dp_valid) begin
                        res_data  <= dp_result;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_dp_operand_feeder.sv
// tb_dp_operand_feeder: directed and randomized operations checked against a dot-product and latency model
module tb_dp_operand_feeder;
    localparam int N = 8, W = 8, RW = 19, TO = 16;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, res_ready = 1'b0, dp_valid = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic [RW-1:0] dp_result = '0;
    logic in_ready, compute, res_valid, res_err, busy;
    logic [N*W-1:0] vec_a, vec_b;
    logic [RW-1:0] res_data;
    int checks = 0, errors = 0;
    string cur = "reset";

    dp_operand_feeder #(.N_ELEM(N), .ELEM_W(W), .RES_W(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .vec_a(vec_a), .vec_b(vec_b), .compute(compute), .dp_valid(dp_valid), .dp_result(dp_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", cur, tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] dot(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(a[i*W +: W]) * int'(b[i*W +: W]);
        return RW'(s);
    endfunction

    task automatic load(input logic [N*W-1:0] va, input logic [N*W-1:0] vb, input int gap_pos, input int gap_len);
        for (int i = 0; i < N; i++) begin
            if (i == gap_pos)
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
                    @(negedge clk);
                    check("in_ready_stall", in_ready, 1);
                end
            check("in_ready_load", in_ready, 1);
            in_valid = 1'b1; in_a = va[i*W +: W]; in_b = vb[i*W +: W];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [N*W-1:0] va, input logic [N*W-1:0] vb,
                         input int lat, input int gap_pos, input int gap_len, input int hold);
        logic [RW-1:0] exp_d;
        logic exp_e;
        int exp_lat, got_lat, pulses;
        cur = name;
        exp_e = (lat < 1 || lat > TO);
        exp_d = exp_e ? '0 : dot(va, vb);
        exp_lat = exp_e ? TO + 1 : lat + 1;
        load(va, vb, gap_pos, gap_len);
        check("compute_pulse", compute, 1);
        check("vec_a_at_compute", vec_a, va);
        check("vec_b_at_compute", vec_b, vb);
        check("busy_issue", busy, 1);
        check("in_ready_issue", in_ready, 0);
        pulses = 1; got_lat = -1;
        dp_valid = 1'b0; in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
        for (int i = 1; i <= TO + 8 && got_lat < 0; i++) begin
            @(negedge clk);
            pulses += int'(compute);
            if (res_valid) got_lat = i;
            else begin
                check("vec_a_wait", vec_a, va);
                dp_valid = (i == lat);
                dp_result = (i == lat) ? dot(va, vb) : RW'($urandom);
            end
        end
        dp_valid = 1'b0;
        check("res_latency", 64'(got_lat), 64'(exp_lat));
        check("compute_count", 64'(pulses), 1);
        for (int h = 0; h <= hold; h++) begin
            check("res_valid", res_valid, 1);
            check("res_data", res_data, exp_d);
            check("res_err", res_err, exp_e);
            check("in_ready_resp", in_ready, 0);
            check("busy_resp", busy, 1);
            check("vec_b_resp", vec_b, vb);
            dp_valid = (h == 0); dp_result = RW'($urandom) | 1;
            res_ready = (h == hold);
            if (h == hold) in_valid = 1'b0;
            @(negedge clk);
        end
        dp_valid = 1'b0; res_ready = 1'b0;
        check("in_ready_after", in_ready, 1);
        check("res_valid_after", res_valid, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        logic [N*W-1:0] va, vb;
        repeat (2) @(negedge clk);
        check("in_ready_rst", in_ready, 0);
        check("vec_a_rst", vec_a, 0);
        check("vec_b_rst", vec_b, 0);
        check("compute_rst", compute, 0);
        check("res_valid_rst", res_valid, 0);
        check("res_data_rst", res_data, 0);
        check("res_err_rst", res_err, 0);
        check("busy_rst", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_release", in_ready, 1);

        va = 64'h0807060504030201; vb = 64'h0202020202020202;
        do_op("basic", va, vb, 2, -1, 0, 0);
        do_op("max", {N*W{1'b1}}, {N*W{1'b1}}, 5, -1, 0, 1);
        do_op("stall", va, vb, 2, 4, 3, 5);
        do_op("timeout", {$urandom, $urandom}, {$urandom, $urandom}, -1, -1, 0, 2);
        do_op("boundary", {$urandom, $urandom}, {$urandom, $urandom}, TO, -1, 0, 0);

        cur = "reset_mid";
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = W'($urandom) | 1; in_b = W'($urandom) | 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("in_ready_rst_mid", in_ready, 0);
        check("vec_a_rst_mid", vec_a, 0);
        check("vec_b_rst_mid", vec_b, 0);
        check("busy_rst_mid", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst_mid", in_ready, 1);
        do_op("after_reset", {$urandom, $urandom}, {$urandom, $urandom}, 3, -1, 0, 0);

        repeat (8) do_op("random", {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(1, TO + 3)),
                         int'($urandom_range(0, N)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
